// File: rtl/instr_fetch.sv
// Instruction fetch and PC sequencing stage ahead of the MIPS datapath.
// Fetches one word per instruction, holds it for execution, then steps the PC.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        zero,
  input  logic [31:0] imm32,
  output logic [31:0] instret,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  // Word offset scaled to bytes; bits shifted past bit 31 are dropped.
  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic signed [31:0] offs);
    logic signed [31:0] offs_bytes;
    offs_bytes = offs <<< 2;
    return base + offs_bytes;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        instret_q, instret_d;
  logic               err_q, err_d;
  logic [7:0]         wait_q, wait_d;
  logic               boot_hold_q;
  logic [31:0]        next_pc;
  logic               take_br;
  logic signed [31:0] imm_s;

  assign imm_s       = imm32;
  assign pc_plus4    = pc_q + 32'd4;
  assign take_br     = (branch & zero) | (branch_ne & ~zero);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (take_br) begin
      next_pc = branch_target(pc_plus4, imm_s);
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    err_d     = err_q;
    wait_d    = wait_q;
    case (state_q)
      BOOT: begin
        // boot_hold_q keeps BOOT for the first cycle after reset release.
        if (!boot_hold_q) begin
          state_d = FETCH;
          wait_d  = 8'd0;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      EXEC: begin
        if (advance) begin
          instret_d = instret_q + 32'd1;
          pc_d      = next_pc;
          wait_d    = 8'd0;
          state_d   = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      instr_q     <= 32'd0;
      instret_q   <= 32'd0;
      err_q       <= 1'b0;
      wait_q      <= 8'd0;
      boot_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      instret_q   <= instret_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
      boot_hold_q <= 1'b0;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == EXEC);
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign instret     = instret_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: driver queues expected EXEC contents,
// a monitor pops and compares whenever the DUT enters EXEC.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int unsigned MW  = 4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        branch;
  logic        branch_ne;
  logic        jump;
  logic        zero;
  logic [31:0] imm32;
  logic [31:0] instret;
  logic        fetch_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instret;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests;
  int          n_fail;
  logic [31:0] exp_instret;

  instr_fetch #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .advance(advance), .branch(branch), .branch_ne(branch_ne),
    .jump(jump), .zero(zero), .imm32(imm32),
    .instret(instret), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: compare on every entry into EXEC.
  initial begin : monitor
    logic prev_vld;
    exp_t e;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && !prev_vld) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_exec: got pc %h expected no instruction", pc);
        end else begin
          e = sb_q.pop_front();
          check32("exec_pc", pc, e.pc);
          check32("exec_instr", instruction, e.instr);
          check32("exec_instret", instret, e.instret);
        end
      end
      prev_vld = instr_valid;
    end
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: got imem_req 0 expected 1 within 10 cycles");
    end
  endtask

  // Serve one fetch after 'waits' stall cycles; returns in the first EXEC cycle.
  task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] word, input int waits);
    bit   ok;
    exp_t e;
    wait_req(ok);
    if (!ok) return;
    check32("imem_addr", imem_addr, exp_pc);
    repeat (waits) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = word;
    e.pc       = exp_pc;
    e.instr    = word;
    e.instret  = exp_instret;
    sb_q.push_back(e);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
  endtask

  task automatic exec(input int hold, input logic j, input logic b, input logic bne,
                      input logic z, input logic [31:0] imm, input logic [31:0] exp_next);
    repeat (hold) @(negedge clk);
    if (hold > 0) check1("exec_hold", instr_valid, 1'b1);
    advance   = 1'b1;
    jump      = j;
    branch    = b;
    branch_ne = bne;
    zero      = z;
    imm32     = imm;
    @(negedge clk);
    advance   = 1'b0;
    jump      = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    zero      = 1'b0;
    imm32     = 32'd0;
    exp_instret++;
    check1("req_after_adv", imem_req, 1'b1);
    check32("next_pc", imem_addr, exp_next);
    check32("instret", instret, exp_instret);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    n_tests     = 0;
    n_fail      = 0;
    exp_instret = 32'd0;
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    advance     = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    jump        = 1'b0;
    zero        = 1'b0;
    imm32       = 32'd0;
    repeat (2) @(negedge clk);

    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check32("rst_pc", pc, RPC);
    check32("rst_pc_plus4", pc_plus4, 32'h4);
    check32("rst_instr", instruction, 32'd0);
    check32("rst_instret", instret, 32'd0);
    check1("rst_err", fetch_err, 1'b0);

    rst = 1'b0;
    @(negedge clk);
    check1("boot_req", imem_req, 1'b0);
    @(negedge clk);
    check1("first_req", imem_req, 1'b1);
    check32("first_addr", imem_addr, 32'h0);

    // Sequential fetch
    fetch(32'h0000_0000, 32'h2008_0001, 0); exec(0, 0, 0, 0, 0, 32'h0, 32'h0000_0004);
    fetch(32'h0000_0004, 32'h2009_0002, 0); exec(0, 0, 0, 0, 0, 32'h0, 32'h0000_0008);
    fetch(32'h0000_0008, 32'h0109_5020, 0); exec(0, 0, 0, 0, 0, 32'h0, 32'h0000_000C);
    fetch(32'h0000_000C, 32'hAC0A_0004, 0); exec(0, 0, 0, 0, 0, 32'h0, 32'h0000_0010);
    check32("instret_four", instret, 32'd4);

    // Branches: forward BEQ to 0x100, back BEQ to 0xFC, BNE not taken / taken, BEQ not taken
    fetch(32'h0000_0010, 32'h1000_003B, 0); exec(0, 0, 1, 0, 1, 32'h0000_003B, 32'h0000_0100);
    fetch(32'h0000_0100, 32'h1000_FFFE, 1); exec(3, 0, 1, 0, 1, 32'hFFFF_FFFE, 32'h0000_00FC);
    fetch(32'h0000_00FC, 32'h1400_0001, 0); exec(0, 0, 0, 1, 1, 32'h0000_0001, 32'h0000_0100);
    fetch(32'h0000_0100, 32'h1400_0001, 0); exec(0, 0, 0, 1, 0, 32'h0000_0001, 32'h0000_0108);
    fetch(32'h0000_0108, 32'h1000_0005, 0); exec(0, 0, 1, 0, 0, 32'h0000_0005, 32'h0000_010C);
    // Offset whose top bits fall off when scaled: 0x110 + 0xEFFFFF00
    fetch(32'h0000_010C, 32'h1000_FFC0, 2); exec(0, 0, 1, 0, 1, 32'hFBFF_FFC0, 32'hF000_0010);

    // Jump beats a taken branch; then jump to the last word of memory
    fetch(32'hF000_0010, 32'h0800_0040, 0); exec(0, 1, 1, 0, 1, 32'h0000_0004, 32'hF000_0100);
    fetch(32'hF000_0100, 32'h0BFF_FFFF, 0); exec(0, 1, 0, 0, 0, 32'h0, 32'hFFFF_FFFC);
    check32("wrap_pc_plus4", pc_plus4, 32'h0);

    // Ack on the 4th request cycle is accepted; PC wraps to 0
    fetch(32'hFFFF_FFFC, 32'h2000_0000, 3);
    check1("late_ack_err", fetch_err, 1'b0);
    exec(0, 0, 0, 0, 0, 32'h0, 32'h0000_0000);

    // Timeout: no ack for MAX_WAIT cycles
    repeat (3) @(negedge clk);
    check1("to_err_before", fetch_err, 1'b0);
    check1("to_req_before", imem_req, 1'b1);
    @(negedge clk);
    check1("to_err", fetch_err, 1'b1);
    check1("to_req", imem_req, 1'b0);
    check1("to_valid", instr_valid, 1'b0);
    advance  = 1'b1;
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    advance  = 1'b0;
    imem_ack = 1'b0;
    check1("halt_err", fetch_err, 1'b1);
    check1("halt_req", imem_req, 1'b0);
    check1("halt_valid", instr_valid, 1'b0);
    check32("halt_instret", instret, exp_instret);

    // Reset leaves HALT
    rst = 1'b1;
    @(negedge clk);
    check1("halt_rst_err", fetch_err, 1'b0);
    check1("halt_rst_req", imem_req, 1'b0);
    rst = 1'b0;
    exp_instret = 32'd0;
    @(negedge clk);
    check1("halt_rst_boot", imem_req, 1'b0);
    @(negedge clk);
    check1("halt_rst_req2", imem_req, 1'b1);

    // Reset in the same cycle as an ack
    fetch(32'h0000_0000, 32'h1234_5678, 0); exec(0, 0, 0, 0, 0, 32'h0, 32'h0000_0004);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst        = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    rst        = 1'b0;
    exp_instret = 32'd0;
    check32("mid_rst_instr", instruction, 32'd0);
    check32("mid_rst_pc", pc, RPC);
    check32("mid_rst_instret", instret, 32'd0);
    check1("mid_rst_valid", instr_valid, 1'b0);
    check1("mid_rst_req", imem_req, 1'b0);
    @(negedge clk);
    check1("mid_rst_boot", imem_req, 1'b0);
    @(negedge clk);
    check1("mid_rst_req2", imem_req, 1'b1);
    check32("mid_rst_addr", imem_addr, RPC);

    @(negedge clk);
    check32("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
